// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory access controller.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_ld_addr_gen.sv
// Load write-address counter: word-aligned start, +WORD_BYTES per written beat,
// and a flag telling whether the current address lies outside the IMEM window.
module imem_ld_addr_gen
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              out_of_range_o
);

  localparam int unsigned       WORD_SHIFT = $clog2(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  logic [ADDR_W-1:0] addr_reg;
  logic              wrap_reg;
  logic [ADDR_W:0]   addr_next;
  logic [ADDR_W-1:0] word_idx;

  assign addr_next = {1'b0, addr_reg} + (ADDR_W + 1)'(WORD_BYTES);
  assign word_idx  = (addr_reg - BASE_ADDR) >> WORD_SHIFT;

  // A carry out of the counter is remembered so a wrapped address never looks valid again.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_reg <= '0;
      wrap_reg <= 1'b0;
    end else if (load_i) begin
      addr_reg <= base_i & ALIGN_MASK;
      wrap_reg <= 1'b0;
    end else if (inc_i) begin
      addr_reg <= addr_next[ADDR_W-1:0];
      wrap_reg <= wrap_reg | addr_next[ADDR_W];
    end
  end

  assign addr_o         = addr_reg;
  assign out_of_range_o = wrap_reg | (word_idx >= ADDR_W'(MEM_WORDS));

endmodule

// File: rtl/imem_access_ctrl.sv
// Arbitrates the single IMEM port between fetch reads and exclusive program-load writes.
module imem_access_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_gnt_o,
  output logic              fetch_rvalid_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_base_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  output logic              ld_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wr_en_o,
  output logic              mem_rd_en_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  state_e            state_reg;
  logic              err_reg;
  logic              rvalid_reg;
  logic              in_idle, in_load, in_done;
  logic              start_acc, gnt, beat, wr, oor;
  logic [ADDR_W-1:0] ld_addr;

  // Everything is gated by rst_ni so the port goes quiet the moment reset is applied.
  assign in_idle   = rst_ni && (state_reg == IDLE);
  assign in_load   = rst_ni && (state_reg == LOAD);
  assign in_done   = rst_ni && (state_reg == DONE);
  assign start_acc = in_idle & ld_start_i;
  assign gnt       = in_idle & fetch_req_i & ~ld_start_i;
  assign beat      = in_load & ld_valid_i;
  assign wr        = beat & ~oor;

  imem_ld_addr_gen #(
    .ADDR_W    (ADDR_W),
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .load_i         (start_acc),
    .base_i         (ld_base_i),
    .inc_i          (wr),
    .addr_o         (ld_addr),
    .out_of_range_o (oor)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      err_reg    <= 1'b0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= gnt;
      case (state_reg)
        IDLE: begin
          if (ld_start_i) begin
            state_reg <= LOAD;
            err_reg   <= 1'b0;
          end
        end
        LOAD: begin
          if (beat) begin
            if (oor) begin
              err_reg   <= 1'b1;
              state_reg <= DONE;
            end else if (ld_last_i) begin
              state_reg <= DONE;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt) begin
      mem_addr_o = fetch_addr_i & ALIGN_MASK;
    end else if (wr) begin
      mem_addr_o  = ld_addr;
      mem_wdata_o = ld_data_i;
    end
  end

  assign mem_rd_en_o    = gnt;
  assign mem_wr_en_o    = wr;
  assign fetch_gnt_o    = gnt;
  assign fetch_rvalid_o = rst_ni & rvalid_reg;
  assign fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : '0;
  assign ld_ready_o     = in_load;
  assign ld_busy_o      = in_load | in_done;
  assign ld_done_o      = in_done;
  assign ld_err_o       = rst_ni & err_reg;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl: a 1024-word instance plus a 4-word instance for overflow.
module tb_imem_access_ctrl;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // main instance
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] ld_base = '0, ld_data = '0;
  logic        ready, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wr, rd;

  // small instance (MEM_WORDS = 4)
  logic        s_rst_n = 1'b0;
  logic        s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [31:0] s_base = '0, s_data = '0;
  logic        s_gnt, s_rvalid, s_ready, s_busy, s_done, s_err, s_wr, s_rd;
  logic [31:0] s_rdata, s_addr, s_wdata;
  logic [31:0] s_mem_rdata = '0;
  logic        s_fetch_req = 1'b0;
  logic [31:0] s_fetch_addr = '0;

  imem_access_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_n),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
    .fetch_gnt_o(gnt), .fetch_rvalid_o(rvalid), .fetch_rdata_o(rdata),
    .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_valid_i(ld_valid),
    .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(ready), .ld_busy_o(busy), .ld_done_o(done), .ld_err_o(err),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wr_en_o(wr),
    .mem_rd_en_o(rd), .mem_rdata_i(mem_rdata)
  );

  imem_access_ctrl #(.MEM_WORDS(4)) dut_small (
    .clk_i(clk_i), .rst_ni(s_rst_n),
    .fetch_req_i(s_fetch_req), .fetch_addr_i(s_fetch_addr),
    .fetch_gnt_o(s_gnt), .fetch_rvalid_o(s_rvalid), .fetch_rdata_o(s_rdata),
    .ld_start_i(s_start), .ld_base_i(s_base), .ld_valid_i(s_valid),
    .ld_data_i(s_data), .ld_last_i(s_last),
    .ld_ready_o(s_ready), .ld_busy_o(s_busy), .ld_done_o(s_done), .ld_err_o(s_err),
    .mem_addr_o(s_addr), .mem_wdata_o(s_wdata), .mem_wr_en_o(s_wr),
    .mem_rd_en_o(s_rd), .mem_rdata_i(s_mem_rdata)
  );

  function automatic logic [31:0] pre(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // IMEM model with registered read, write counter and port-conflict counter
  logic [31:0] mem [0:63];
  logic        preload = 1'b1;
  int          wr_cnt = 0, both_cnt = 0, s_wr_cnt = 0;

  always @(posedge clk_i) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= pre(i);
    end else begin
      if (rd) mem_rdata <= mem[mem_addr[7:2]];
      if (wr) begin
        mem[mem_addr[7:2]] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
    end
    if (rd && wr) both_cnt <= both_cnt + 1;
    if (s_wr) s_wr_cnt <= s_wr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    int w0;
    tick();
    preload = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h24;
    @(negedge clk_i);
    checks++;
    if (gnt !== 1'b1) begin failures++; $display("FAIL rst_pre_gnt got=%b exp=1", gnt); end
    tick();
    ld_start = 1'b1; ld_base = 32'h0;
    @(negedge clk_i);
    checks++;
    if (gnt !== 1'b0) begin failures++; $display("FAIL rst_start_gnt got=%b exp=0", gnt); end
    tick();
    w0 = wr_cnt;
    ld_start = 1'b0; rst_n = 1'b0; ld_valid = 1'b1; ld_data = 32'hBAD0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      checks++;
      if ({gnt, rvalid, rdata, ready, busy, done, err, mem_addr, mem_wdata, wr, rd} !== '0) begin
        failures++;
        $display("FAIL rst_outs_%0d got gnt=%b rv=%b rd=%h rdy=%b busy=%b done=%b err=%b a=%h wd=%h we=%b re=%b exp all 0",
                 k, gnt, rvalid, rdata, ready, busy, done, err, mem_addr, mem_wdata, wr, rd);
      end
      if (k == 0) tick();
    end
    tick();
    rst_n = 1'b1; ld_valid = 1'b0; fetch_req = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({gnt, rvalid, ready, busy, done, err, wr, rd, mem_addr} !== '0) begin
      failures++;
      $display("FAIL rst_idle_outs got busy=%b rdy=%b err=%b we=%b re=%b exp all 0", busy, ready, err, wr, rd);
    end
    checks++;
    if (wr_cnt !== w0) begin failures++; $display("FAIL rst_no_write got=%0d exp=%0d", wr_cnt, w0); end
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 6; i++) begin
      tick();
      fetch_req = 1'b1; fetch_addr = 32'(4 * i);
      @(negedge clk_i);
      checks++;
      if ({gnt, rd, wr, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'(4 * i)}) begin
        failures++;
        $display("FAIL fetch_gnt_%0d got gnt=%b re=%b we=%b a=%h exp 1 1 0 %h", i, gnt, rd, wr, mem_addr, 4 * i);
      end
      if (i > 0) begin
        checks++;
        if ({rvalid, rdata} !== {1'b1, pre(i - 1)}) begin
          failures++;
          $display("FAIL fetch_rdata_%0d got rv=%b d=%h exp 1 %h", i - 1, rvalid, rdata, pre(i - 1));
        end
      end
    end
    tick();
    fetch_req = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({rvalid, rdata, gnt, rd} !== {1'b1, pre(5), 2'b00}) begin
      failures++;
      $display("FAIL fetch_tail got rv=%b d=%h gnt=%b re=%b exp 1 %h 0 0", rvalid, rdata, gnt, rd, pre(5));
    end
    tick();
    @(negedge clk_i);
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL fetch_rv_drop got=%b exp=0", rvalid); end
  endtask

  task automatic test_load();
    logic vpat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int k = 0;
    int w0 = wr_cnt;
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h8; ld_start = 1'b1; ld_base = 32'h0;
    @(negedge clk_i);
    checks++;
    if ({gnt, rd, busy} !== 3'b000) begin failures++; $display("FAIL load_start got gnt=%b re=%b busy=%b exp 0 0 0", gnt, rd, busy); end
    tick();
    ld_start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      ld_valid = vpat[c];
      ld_data  = vpat[c] ? 32'hA0 + 32'(k) : 32'hDEAD;
      ld_last  = vpat[c] && (k == 3);
      @(negedge clk_i);
      checks++;
      if ({gnt, rd, ready, busy, done} !== 5'b00110) begin
        failures++;
        $display("FAIL load_ctl_%0d got gnt=%b re=%b rdy=%b busy=%b done=%b exp 0 0 1 1 0", c, gnt, rd, ready, busy, done);
      end
      checks++;
      if (vpat[c]) begin
        if ({wr, mem_addr, mem_wdata} !== {1'b1, 32'(4 * k), 32'hA0 + 32'(k)}) begin
          failures++;
          $display("FAIL load_beat_%0d got we=%b a=%h d=%h exp 1 %h %h", c, wr, mem_addr, mem_wdata, 4 * k, 32'hA0 + 32'(k));
        end
        k++;
      end else if (wr !== 1'b0) begin
        failures++;
        $display("FAIL load_gap_%0d got we=%b exp 0", c, wr);
      end
    end
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({done, busy, ready, gnt, wr} !== 5'b11000) begin
      failures++;
      $display("FAIL load_done got done=%b busy=%b rdy=%b gnt=%b we=%b exp 1 1 0 0 0", done, busy, ready, gnt, wr);
    end
    tick();
    @(negedge clk_i);
    checks++;
    if ({done, busy, gnt} !== 3'b001) begin
      failures++;
      $display("FAIL load_back_idle got done=%b busy=%b gnt=%b exp 0 0 1", done, busy, gnt);
    end
    fetch_req = 1'b0;
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== {32'hA0, 32'hA1, 32'hA2, 32'hA3} || (wr_cnt - w0) !== 4) begin
      failures++;
      $display("FAIL load_mem got %h %h %h %h n=%0d exp a0 a1 a2 a3 n=4", mem[0], mem[1], mem[2], mem[3], wr_cnt - w0);
    end
  endtask

  task automatic test_start_vs_fetch();
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h12;
    @(negedge clk_i);
    checks++;
    if ({gnt, rd, mem_addr} !== {2'b11, 32'h10}) begin
      failures++;
      $display("FAIL svf_grant got gnt=%b re=%b a=%h exp 1 1 10", gnt, rd, mem_addr);
    end
    tick();
    ld_start = 1'b1; ld_base = 32'h22; fetch_addr = 32'h40;
    @(negedge clk_i);
    checks++;
    if ({gnt, rd, rvalid, rdata} !== {3'b001, pre(4)}) begin
      failures++;
      $display("FAIL svf_collide got gnt=%b re=%b rv=%b d=%h exp 0 0 1 %h", gnt, rd, rvalid, rdata, pre(4));
    end
    tick();
    ld_base = 32'h80;
    @(negedge clk_i);
    checks++;
    if ({busy, ready, rvalid, gnt} !== 4'b1100) begin
      failures++;
      $display("FAIL svf_in_load got busy=%b rdy=%b rv=%b gnt=%b exp 1 1 0 0", busy, ready, rvalid, gnt);
    end
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'hB0;
    @(negedge clk_i);
    checks++;
    if ({wr, mem_addr, mem_wdata} !== {1'b1, 32'h20, 32'hB0}) begin
      failures++;
      $display("FAIL svf_beat got we=%b a=%h d=%h exp 1 20 b0", wr, mem_addr, mem_wdata);
    end
    tick();
    ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b1;
    @(negedge clk_i);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL svf_done got=%b exp=1", done); end
    tick();
    ld_start = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({busy, ready, gnt} !== 3'b001) begin
      failures++;
      $display("FAIL svf_idle got busy=%b rdy=%b gnt=%b exp 0 0 1", busy, ready, gnt);
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_a [2] = '{32'h8, 32'hC};
    tick();
    s_rst_n = 1'b1;
    tick();
    s_start = 1'b1; s_base = 32'h8;
    @(negedge clk_i);
    checks++;
    if ({s_busy, s_err} !== 2'b00) begin failures++; $display("FAIL ovf_idle got busy=%b err=%b exp 0 0", s_busy, s_err); end
    tick();
    s_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) tick();
      s_valid = 1'b1; s_data = 32'hD0 + 32'(b); s_last = (b == 2);
      @(negedge clk_i);
      checks++;
      if (b < 2) begin
        if ({s_wr, s_addr, s_wdata, s_err} !== {1'b1, exp_a[b], 32'hD0 + 32'(b), 1'b0}) begin
          failures++;
          $display("FAIL ovf_beat_%0d got we=%b a=%h d=%h err=%b exp 1 %h %h 0", b, s_wr, s_addr, s_wdata, s_err, exp_a[b], 32'hD0 + 32'(b));
        end
      end else if ({s_wr, s_err, s_rd} !== 3'b000) begin
        failures++;
        $display("FAIL ovf_drop got we=%b err=%b re=%b exp 0 0 0", s_wr, s_err, s_rd);
      end
    end
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({s_done, s_err, s_busy} !== 3'b111) begin
      failures++;
      $display("FAIL ovf_done got done=%b err=%b busy=%b exp 1 1 1", s_done, s_err, s_busy);
    end
    tick();
    @(negedge clk_i);
    checks++;
    if ({s_done, s_err, s_busy, 32'(s_wr_cnt)} !== {3'b010, 32'd2}) begin
      failures++;
      $display("FAIL ovf_sticky got done=%b err=%b busy=%b writes=%0d exp 0 1 0 2", s_done, s_err, s_busy, s_wr_cnt);
    end
    tick();
    s_start = 1'b1; s_base = 32'h0;
    tick();
    s_start = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({s_err, s_busy} !== 2'b01) begin failures++; $display("FAIL ovf_err_clear got err=%b busy=%b exp 0 1", s_err, s_busy); end
    s_valid = 1'b1; s_last = 1'b1; s_data = 32'hE0;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({s_done, s_err} !== 2'b10) begin failures++; $display("FAIL ovf_reload_done got done=%b err=%b exp 1 0", s_done, s_err); end
  endtask

  task automatic test_reset_mid_load();
    int w0 = wr_cnt;
    tick();
    ld_start = 1'b1; ld_base = 32'h30;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hC1;
    @(negedge clk_i);
    checks++;
    if ({wr, mem_addr} !== {1'b1, 32'h30}) begin failures++; $display("FAIL rml_beat0 got we=%b a=%h exp 1 30", wr, mem_addr); end
    tick();
    ld_data = 32'hC2;
    @(negedge clk_i);
    checks++;
    if ({wr, mem_addr} !== {1'b1, 32'h34}) begin failures++; $display("FAIL rml_beat1 got we=%b a=%h exp 1 34", wr, mem_addr); end
    tick();
    rst_n = 1'b0; ld_data = 32'hC3;
    @(negedge clk_i);
    checks++;
    if ({wr, done, busy} !== 3'b000) begin failures++; $display("FAIL rml_in_reset got we=%b done=%b busy=%b exp 0 0 0", wr, done, busy); end
    tick();
    rst_n = 1'b1; ld_data = 32'hC4;
    @(negedge clk_i);
    checks++;
    if ({busy, ready, wr, done} !== 4'b0000) begin
      failures++;
      $display("FAIL rml_after got busy=%b rdy=%b we=%b done=%b exp 0 0 0 0", busy, ready, wr, done);
    end
    tick();
    ld_valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({done, busy} !== 2'b00) begin failures++; $display("FAIL rml_no_done got done=%b busy=%b exp 0 0", done, busy); end
    checks++;
    if ({mem[12], mem[13], mem[14]} !== {32'hC1, 32'hC2, pre(14)} || (wr_cnt - w0) !== 2) begin
      failures++;
      $display("FAIL rml_mem got %h %h %h n=%0d exp c1 c2 %h n=2", mem[12], mem[13], mem[14], wr_cnt - w0, pre(14));
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_start_vs_fetch();
    test_overflow();
    test_reset_mid_load();
    checks++;
    if (both_cnt !== 0) begin failures++; $display("FAIL port_conflict got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
